// File: rtl/jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// jk_cmd_sequencer
//
// Upstream driver for a JK flip-flop (ffJK). Commands (HOLD/RESET/SET/TOGGLE)
// are accepted over a valid/ready handshake into a small FIFO, then issued one
// at a time. Each command drives j/k for exactly one clock edge, and on the
// following cycle the flip-flop's Q is compared against an internal model.
// Mismatches set a sticky flag and bump a saturating counter. The model is
// resynchronised to the observed Q after a mismatch so that a single fault
// is counted once.
//
// Parameters
//   DEPTH  command FIFO entries (power of two, >= 2)
//   CNT_W  width of the saturating mismatch counter
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous, active-high
//   cmd_valid   command offered by the source
//   cmd_ready   FIFO can accept (not full, from the registered level)
//   cmd_op      00 HOLD, 01 RESET (j0k1), 10 SET (j1k0), 11 TOGGLE (j1k1)
//   q_fb        Q returned from ffJK
//   err_clear   clears err_sticky / err_count
//   j, k        registered drive to ffJK
//   expected_q  model of ffJK Q
//   busy        sequencer active or commands pending
//   err_sticky  set on any mismatch
//   err_count   saturating mismatch count
//   fifo_level  number of queued commands
// -----------------------------------------------------------------------------
module jk_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic                       q_fb,
   input  logic                       err_clear,
   output logic                       j,
   output logic                       k,
   output logic                       expected_q,
   output logic                       busy,
   output logic                       err_sticky,
   output logic [CNT_W-1:0]           err_count,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [1:0] OP_HOLD   = 2'b00;
   localparam logic [1:0] OP_RESET  = 2'b01;
   localparam logic [1:0] OP_SET    = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level;
   logic [1:0]       cur_op;
   logic [1:0]       head_op;
   logic             push;
   logic             pop;
   logic             mismatch;

   assign cmd_ready  = (level != LW'(DEPTH));
   assign push       = cmd_valid && cmd_ready;
   assign head_op    = mem[rd_ptr];
   // A new command is taken from the FIFO either from IDLE or straight out
   // of CHECK, which gives back-to-back issue at one command per two cycles.
   assign pop        = ((state == IDLE) || (state == CHECK)) && (level != '0);
   assign mismatch   = (state == CHECK) && (q_fb != expected_q);
   assign busy       = (state != IDLE) || (level != '0);
   assign fifo_level = level;

   // Storage needs no reset: entries are only read when level says they
   // were written since the last reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= cmd_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         state      <= IDLE;
         cur_op     <= OP_HOLD;
         j          <= 1'b0;
         k          <= 1'b0;
         expected_q <= 1'b0;
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else begin
         // FIFO pointers and level; pointers wrap naturally (DEPTH is 2^AW)
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase

         // Sequencer
         case (state)
            IDLE: begin
               // Follow Q while idle so asynchronous preset/clear of the
               // flip-flop is absorbed without flagging an error.
               expected_q <= q_fb;
               if (pop) begin
                  j      <= head_op[1];
                  k      <= head_op[0];
                  cur_op <= head_op;
                  state  <= ISSUE;
               end else begin
                  j <= 1'b0;
                  k <= 1'b0;
               end
            end

            ISSUE: begin
               // ffJK samples j/k at the end of this cycle
               case (cur_op)
                  OP_RESET:  expected_q <= 1'b0;
                  OP_SET:    expected_q <= 1'b1;
                  OP_TOGGLE: expected_q <= ~expected_q;
                  default:   expected_q <= expected_q;
               endcase
               j     <= 1'b0;
               k     <= 1'b0;
               state <= CHECK;
            end

            CHECK: begin
               if (mismatch) begin
                  expected_q <= q_fb;
               end
               if (pop) begin
                  j      <= head_op[1];
                  k      <= head_op[0];
                  cur_op <= head_op;
                  state  <= ISSUE;
               end else begin
                  j     <= 1'b0;
                  k     <= 1'b0;
                  state <= IDLE;
               end
            end

            default: begin
               j     <= 1'b0;
               k     <= 1'b0;
               state <= IDLE;
            end
         endcase

         // Error tracking: a mismatch wins over a coincident clear, and
         // then counts as the first error after the clear.
         if (mismatch) begin
            err_sticky <= 1'b1;
            if (err_clear) begin
               err_count <= CNT_W'(1);
            end else if (err_count != '1) begin
               err_count <= err_count + CNT_W'(1);
            end
         end else if (err_clear) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jk_cmd_sequencer
//
// Drives jk_cmd_sequencer against a behavioural JK flip-flop with async
// preset/clear. Each accepted command is queued with its expected Q; when the
// DUT pops it (seen as a level drop), j/k are checked, then expected_q and Q
// one edge later, then the error counters one edge after that.
// -----------------------------------------------------------------------------
module tb_jk_cmd_sequencer;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 3;
   localparam int LW      = $clog2(DEPTH) + 1;
   localparam int MAX_CNT = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic             q_fb;
   logic             err_clear;
   logic             j;
   logic             k;
   logic             expected_q;
   logic             busy;
   logic             err_sticky;
   logic [CNT_W-1:0] err_count;
   logic [LW-1:0]    fifo_level;

   always #5 clk = ~clk;

   jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .q_fb       (q_fb),
      .err_clear  (err_clear),
      .j          (j),
      .k          (k),
      .expected_q (expected_q),
      .busy       (busy),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .fifo_level (fifo_level)
   );

   // Behavioural ffJK with async clear/preset; force0 models a stuck-at-0 Q
   logic ff_q;
   logic ff_pre = 1'b0;
   logic ff_clr = 1'b0;
   logic force0 = 1'b0;

   always @(posedge clk or posedge ff_pre or posedge ff_clr) begin
      if (ff_clr)      ff_q <= 1'b0;
      else if (ff_pre) ff_q <= 1'b1;
      else begin
         case ({j, k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end

   assign q_fb = force0 ? 1'b0 : ff_q;

   typedef struct {
      logic [1:0] op;
      logic       eq;
   } ent_t;

   ent_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   logic mq = 1'b0;        // model Q for the next queued command
   logic m_sticky = 1'b0;
   int   m_cnt = 0;
   logic a_vld = 1'b0;     // popped command now in ISSUE
   ent_t a_ent;
   logic b_vld = 1'b0;     // command now in CHECK
   logic b_mis = 1'b0;
   logic b_q = 1'b0;
   logic clr_on_check = 1'b0;
   logic saw_full = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic nxt(input logic [1:0] op, input logic q);
      case (op)
         2'b00:   return q;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~q;
      endcase
   endfunction

   // One clock: drive inputs, sample pre-edge state at negedge, then check
   // everything observable #1 after the rising edge.
   task automatic tick(input logic v, input logic [1:0] op, input logic clr,
                       input logic rst, output logic acc);
      logic push;
      logic clr_e;
      int   lvb;
      int   pop;
      ent_t e;
      clr_e     = clr | (clr_on_check & b_vld);
      cmd_valid = v;
      cmd_op    = op;
      err_clear = clr_e;
      reset     = rst;
      @(negedge clk);
      push = v && cmd_ready && !rst;
      lvb  = int'(fifo_level);
      if (!cmd_ready) saw_full = 1'b1;
      @(posedge clk);
      #1;
      acc = push;
      if (rst) begin
         sbq.delete();
         a_vld    = 1'b0;
         b_vld    = 1'b0;
         m_sticky = 1'b0;
         m_cnt    = 0;
         chk("rst_jk",     {j, k},     0);
         chk("rst_expq",   expected_q, 0);
         chk("rst_level",  fifo_level, 0);
         chk("rst_ready",  cmd_ready,  1);
         chk("rst_sticky", err_sticky, 0);
         chk("rst_count",  err_count,  0);
      end else begin
         if (b_vld && b_mis) begin
            m_sticky = 1'b1;
            m_cnt    = clr_e ? 1 : ((m_cnt == MAX_CNT) ? m_cnt : m_cnt + 1);
         end else if (clr_e) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
         end
         chk("err_sticky", err_sticky, m_sticky);
         chk("err_count",  err_count,  m_cnt);
         if (b_vld && b_mis) chk("resync", expected_q, b_q);
         b_vld = 1'b0;
         if (a_vld) begin
            chk("jk_clear", {j, k},     0);
            chk("exp_q",    expected_q, a_ent.eq);
            if (!force0) chk("ff_q", q_fb, a_ent.eq);
            b_mis = (q_fb !== a_ent.eq);
            b_q   = q_fb;
            b_vld = 1'b1;
            a_vld = 1'b0;
         end
         if (push) begin
            mq   = nxt(op, mq);
            e.op = op;
            e.eq = mq;
            sbq.push_back(e);
         end
         pop = lvb + (push ? 1 : 0) - int'(fifo_level);
         if (pop == 1) begin
            if (sbq.size() == 0) chk("pop_empty", sbq.size(), 1);
            else begin
               e = sbq.pop_front();
               chk("jk_drive", {j, k}, e.op);
               a_ent = e;
               a_vld = 1'b1;
            end
         end else if (pop != 0) begin
            chk("level_step", pop, 0);
         end
      end
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 1'b0, 1'b0, a);
   endtask

   task automatic push_cmd(input logic [1:0] op);
      logic a;
      int   n;
      n = 0;
      do begin
         tick(1'b1, op, 1'b0, 1'b0, a);
         n++;
      end while (!a && n < 50);
      if (!a) chk("push_timeout", n, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((busy || a_vld || b_vld) && n < 100) begin
         idle(1);
         n++;
      end
      if (n >= 100) chk("drain_timeout", n, 0);
      idle(1);
      chk("drained_sb", sbq.size(), 0);
   endtask

   initial begin
      #1800000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic a;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      err_clear = 1'b0;
      #1 ff_clr = 1'b1;
      tick(1'b0, 2'b00, 1'b0, 1'b1, a);
      tick(1'b0, 2'b00, 1'b0, 1'b1, a);
      ff_clr = 1'b0;
      idle(2);
      chk("init_busy", busy, 0);
      mq = q_fb;

      // 1: single SET
      push_cmd(2'b10);
      drain();
      chk("t1_busy", busy, 0);
      chk("t1_q", q_fb, 1);
      chk("t1_expq", expected_q, 1);

      // 2: continuous stream that fills the FIFO
      saw_full = 1'b0;
      begin
         logic [1:0] ops [8];
         ops = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
         foreach (ops[i]) push_cmd(ops[i]);
      end
      drain();
      chk("t2_full_seen", saw_full, 1);
      chk("t2_count", err_count, 0);
      chk("t2_expq", expected_q, 0);

      // 3: Q stuck at 0
      ff_clr = 1'b1;
      force0 = 1'b1;
      idle(2);
      mq = q_fb;
      push_cmd(2'b10);
      drain();
      chk("t3_sticky", err_sticky, 1);
      chk("t3_count", err_count, 1);
      chk("t3_expq", expected_q, 0);

      // 4: clear coinciding with mismatch, then saturation
      push_cmd(2'b10);
      drain();
      chk("t4_count2", err_count, 2);
      clr_on_check = 1'b1;
      push_cmd(2'b10);
      drain();
      clr_on_check = 1'b0;
      chk("t4_clr_sticky", err_sticky, 1);
      chk("t4_clr_count", err_count, 1);
      for (int i = 0; i < 10; i++) push_cmd(2'b10);
      drain();
      chk("t4_sat", err_count, MAX_CNT);
      tick(1'b0, 2'b00, 1'b1, 1'b0, a);
      chk("t4_cleared", err_count, 0);

      // 5: reset during ISSUE with 3 queued
      force0 = 1'b0;
      ff_clr = 1'b0;
      idle(2);
      mq = q_fb;
      push_cmd(2'b10);
      push_cmd(2'b01);
      push_cmd(2'b10);
      push_cmd(2'b01);
      push_cmd(2'b10);
      push_cmd(2'b01);
      chk("t5_level", fifo_level, 3);
      chk("t5_busy", busy, 1);
      tick(1'b0, 2'b00, 1'b0, 1'b1, a);
      for (int i = 0; i < 6; i++) begin
         idle(1);
         chk("t5_jk_quiet", {j, k}, 0);
         chk("t5_level0", fifo_level, 0);
      end
      chk("t5_idle", busy, 0);
      chk("t5_track", expected_q, q_fb);

      // 6: async preset while idle, then TOGGLE
      ff_clr = 1'b1;
      idle(1);
      ff_clr = 1'b0;
      idle(2);
      chk("t6_low", expected_q, 0);
      ff_pre = 1'b1;
      #2 ff_pre = 1'b0;
      idle(1);
      chk("t6_pre", expected_q, 1);
      chk("t6_noerr", err_sticky, 0);
      mq = q_fb;
      push_cmd(2'b11);
      drain();
      chk("t6_toggle", expected_q, 0);
      chk("t6_noerr2", err_sticky, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
